// File: rtl/connect4_pkg.sv
// Shared types for the board-to-board move link: one-hot move codes,
// transmitter FSM states and a one-hot validity helper.
package connect4_pkg;

    // Move code bit order on the link: {left, right, put}
    typedef logic [2:0] lrp_t;

    localparam lrp_t LRP_LEFT  = 3'b100;
    localparam lrp_t LRP_RIGHT = 3'b010;
    localparam lrp_t LRP_PUT   = 3'b001;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_DRIVE,
        TX_GAP
    } tx_state_t;

    // True only for the three legal move codes; 000 and multi-bit codes are rejected
    function automatic logic is_onehot3(input lrp_t code);
        return (code == LRP_LEFT) || (code == LRP_RIGHT) || (code == LRP_PUT);
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small synchronous FIFO holding queued moves. DEPTH must be a power of two,
// so the read/write pointers wrap naturally. A push into a full FIFO is only
// taken when a pop happens in the same cycle.
module move_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    // Storage write; contents are only ever read behind a valid count
    // NOTE: the memory array is deliberately not reset -- the pointers and count
    // define what is valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/move_transmitter.sv
// Transmit end of the board-to-board move link. Queues one-hot moves and
// drives each onto the opponent wires for PULSE_LEN cycles, followed by
// GAP_LEN idle cycles so the remote stretcher never merges two moves.
// Optional feature: define MOVE_TX_DROP_CNT_EN to add the saturating
// drop_count port counting legal moves lost to a full queue.
module move_transmitter
    import connect4_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 64,
    parameter int DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_valid,
    input  logic [2:0] move_code,
    output logic       move_ready,
    output logic       left_data,
    output logic       right_data,
    output logic       receive_data,
    output logic       busy,
    output logic       code_err
`ifdef MOVE_TX_DROP_CNT_EN
    ,
    output logic [7:0] drop_count
`endif
);

    localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    lrp_t             r_wires;
    logic             r_code_err;

    logic w_code_ok;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    lrp_t w_head;

    assign w_code_ok  = is_onehot3(move_code);
    assign move_ready = ~w_full;
    assign w_push     = move_valid & move_ready & w_code_ok;
    assign w_pop      = (r_state == TX_IDLE) & ~w_empty;

    move_fifo #(
        .WIDTH (3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (move_code),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Pulse/gap sequencer with registered wire outputs
    // NOTE: every assignment in a clocked block is non-blocking so all registers
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_wires <= '0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_wires <= '0;
                    if (!w_empty) begin
                        r_wires <= w_head;
                        r_cnt   <= PULSE_LOAD;
                        r_state <= TX_DRIVE;
                    end
                end
                TX_DRIVE: begin
                    if (r_cnt == '0) begin
                        r_wires <= '0;
                        r_cnt   <= GAP_LOAD;
                        r_state <= TX_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                TX_GAP: begin
                    r_wires <= '0;
                    if (r_cnt == '0) begin
                        r_state <= TX_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_wires <= '0;
                end
            endcase
        end
    end

    // One-cycle flag for an offered move whose code is not one-hot
    always_ff @(posedge clk) begin
        if (rst) r_code_err <= 1'b0;
        else     r_code_err <= move_valid & ~w_code_ok;
    end

    assign left_data    = r_wires[2];
    assign right_data   = r_wires[1];
    assign receive_data = r_wires[0];
    assign code_err     = r_code_err;
    assign busy         = (r_state != TX_IDLE) | ~w_empty;

`ifdef MOVE_TX_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of legal moves refused because the queue was full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (move_valid && !move_ready && w_code_ok && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_move_transmitter.sv
// Directed bench for move_transmitter (PULSE_LEN=4, GAP_LEN=64, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_move_transmitter;

    logic       clk;
    logic       rst;
    logic       move_valid;
    logic [2:0] move_code;
    logic       move_ready;
    logic       left_data;
    logic       right_data;
    logic       receive_data;
    logic       busy;
    logic       code_err;
`ifdef MOVE_TX_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] w_wires;
    assign w_wires = {left_data, right_data, receive_data};

    move_transmitter #(
        .PULSE_LEN (4),
        .GAP_LEN   (64),
        .DEPTH     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .move_valid   (move_valid),
        .move_code    (move_code),
        .move_ready   (move_ready),
        .left_data    (left_data),
        .right_data   (right_data),
        .receive_data (receive_data),
        .busy         (busy),
        .code_err     (code_err)
`ifdef MOVE_TX_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [2:0] seq3  [3];
    logic [2:0] seq6  [6];
    int         rise_t [4];
    logic [2:0] rise_c [4];
    int         n_rise;
    int         n_high;
    int         n_bad;
    logic [2:0] prev;

    initial begin
        seq3 = '{3'b010, 3'b001, 3'b100};
        seq6 = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};

        // ---- 1: reset state ----
        rst        = 1'b1;
        move_valid = 1'b0;
        move_code  = 3'b000;
        tick();
        tick();
        check("rst_wires", 32'(w_wires), 32'h0);
        check("rst_ready", 32'(move_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_code_err", 32'(code_err), 32'h0);
`ifdef MOVE_TX_DROP_CNT_EN
        check("rst_drop_count", 32'(drop_count), 32'h0);
`endif
        rst = 1'b0;
        tick();

        // ---- 2: single left move, latency and pulse width ----
        move_valid = 1'b1;
        move_code  = 3'b100;
        tick();                                   // edge k: push
        move_valid = 1'b0;
        move_code  = 3'b000;
        check("single_k_wires", 32'(w_wires), 32'h0);
        check("single_k_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 4; i++) begin        // edges k+1..k+4
            tick();
            check($sformatf("single_drive_%0d", i), 32'(w_wires), 32'h4);
        end
        tick();                                   // edge k+5
        check("single_end_wires", 32'(w_wires), 32'h0);
        check("single_gap_busy", 32'(busy), 32'h1);
        repeat (63) tick();                       // edge k+68: last GAP cycle
        check("single_gap_last_busy", 32'(busy), 32'h1);
        tick();                                   // edge k+69: IDLE
        check("single_idle_busy", 32'(busy), 32'h0);

        // ---- 3: three back-to-back moves, order and spacing ----
        n_rise = 0;
        n_high = 0;
        n_bad  = 0;
        prev   = 3'b000;
        for (int k = 0; k < 4; k++) begin
            rise_t[k] = -1;
            rise_c[k] = 3'b000;
        end
        for (int i = 0; i < 210; i++) begin
            if (i < 3) begin
                move_valid = 1'b1;
                move_code  = seq3[i];
            end else begin
                move_valid = 1'b0;
                move_code  = 3'b000;
            end
            tick();
            if (w_wires != 3'b000 && prev == 3'b000) begin
                if (n_rise < 4) begin
                    rise_t[n_rise] = i;
                    rise_c[n_rise] = w_wires;
                end
                n_rise++;
            end
            if (w_wires != 3'b000) n_high++;
            if (w_wires != 3'b000 && !$onehot(w_wires)) n_bad++;
            prev = w_wires;
        end
        check("b2b_rises", 32'(n_rise), 32'd3);
        check("b2b_rise0_t", 32'(rise_t[0]), 32'd1);
        check("b2b_rise1_t", 32'(rise_t[1]), 32'd70);
        check("b2b_rise2_t", 32'(rise_t[2]), 32'd139);
        check("b2b_rise0_code", 32'(rise_c[0]), 32'h2);
        check("b2b_rise1_code", 32'(rise_c[1]), 32'h1);
        check("b2b_rise2_code", 32'(rise_c[2]), 32'h4);
        check("b2b_high_cycles", 32'(n_high), 32'd12);
        check("b2b_onehot", 32'(n_bad), 32'd0);
        check("b2b_idle_busy", 32'(busy), 32'h0);

        // ---- 4: overflow, FSM held busy by a primer move ----
        move_valid = 1'b1;
        move_code  = 3'b001;
        tick();                                   // primer pushed
        move_valid = 1'b0;
        tick();                                   // primer popped, DRIVE
        check("ovf_primer_wires", 32'(w_wires), 32'h1);
        for (int i = 0; i < 6; i++) begin
            move_valid = 1'b1;
            move_code  = seq6[i];
            tick();
            check($sformatf("ovf_ready_%0d", i), 32'(move_ready), (i < 3) ? 32'h1 : 32'h0);
        end
        move_valid = 1'b0;
        move_code  = 3'b000;
`ifdef MOVE_TX_DROP_CNT_EN
        check("ovf_drop_count", 32'(drop_count), 32'd2);
`endif
        n_rise = 0;
        prev   = 3'b000;
        for (int k = 0; k < 4; k++) rise_c[k] = 3'b000;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (w_wires != 3'b000 && prev == 3'b000) begin
                if (n_rise < 4) rise_c[n_rise] = w_wires;
                n_rise++;
            end
            prev = w_wires;
        end
        check("ovf_rises", 32'(n_rise), 32'd4);
        check("ovf_code0", 32'(rise_c[0]), 32'h4);
        check("ovf_code1", 32'(rise_c[1]), 32'h2);
        check("ovf_code2", 32'(rise_c[2]), 32'h1);
        check("ovf_code3", 32'(rise_c[3]), 32'h4);
        check("ovf_drain_busy", 32'(busy), 32'h0);
        check("ovf_drain_ready", 32'(move_ready), 32'h1);

        // ---- 5: illegal codes ----
        move_valid = 1'b1;
        move_code  = 3'b110;
        tick();
        check("err110_pulse", 32'(code_err), 32'h1);
        check("err110_busy", 32'(busy), 32'h0);
        move_valid = 1'b0;
        move_code  = 3'b000;
        tick();
        check("err110_clear", 32'(code_err), 32'h0);
        move_valid = 1'b1;
        move_code  = 3'b000;
        tick();
        check("err000_pulse", 32'(code_err), 32'h1);
        move_valid = 1'b0;
        tick();
        check("err000_clear", 32'(code_err), 32'h0);
        tick();
        check("err_wires", 32'(w_wires), 32'h0);
        check("err_busy", 32'(busy), 32'h0);

        // ---- 6: reset during DRIVE with two moves queued ----
        move_valid = 1'b1;
        move_code  = 3'b100;
        tick();                                   // push A
        move_code  = 3'b010;
        tick();                                   // push B, pop A
        check("rstmid_drive1", 32'(w_wires), 32'h4);
        move_code  = 3'b001;
        tick();                                   // push C, 2nd DRIVE cycle
        check("rstmid_drive2", 32'(w_wires), 32'h4);
        move_valid = 1'b0;
        move_code  = 3'b000;
        rst        = 1'b1;
        tick();
        check("rstmid_wires", 32'(w_wires), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_ready", 32'(move_ready), 32'h1);
`ifdef MOVE_TX_DROP_CNT_EN
        check("rstmid_drop_count", 32'(drop_count), 32'h0);
`endif
        rst    = 1'b0;
        n_high = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (w_wires != 3'b000) n_high++;
        end
        check("rstmid_no_pulses", 32'(n_high), 32'd0);
        check("rstmid_final_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
